// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator_if
// Description : Handshake bundle between the ripple-adder stage and the
//               sum accumulator: start pulse, term handshake, result outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       s;
    logic             co;
    logic [ACC_W-1:0] acc;
    logic             acc_valid;
    logic             busy;
    logic             ovf;

    // Producer side: issues start and adder terms, observes results.
    modport master (
        output start, in_valid, s, co,
        input  in_ready, acc, acc_valid, busy, ovf
    );

    // Accumulator side.
    modport slave (
        input  start, in_valid, s, co,
        output in_ready, acc, acc_valid, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Sums NUM_TERMS 5-bit adder results {co,s} into an ACC_W-bit
//               register, then strobes acc_valid for one cycle. ovf is sticky
//               for the run. Optional macro SUM_ACC_SATURATE_EN makes acc
//               clamp to all-ones on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
    parameter int ACC_W     = 8,   // 6..16
    parameter int NUM_TERMS = 4    // 1..15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sum_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] c_last_cnt = 4'(NUM_TERMS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_acc_valid;
    logic             w_accept;
    logic             w_clear;
    logic [ACC_W:0]   w_term;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;

    // One extra bit of headroom exposes the overflow carry.
    assign w_term  = {{(ACC_W-4){1'b0}}, bus.co, bus.s};
    assign w_sum   = {1'b0, r_acc} + w_term;
    assign w_carry = w_sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    // Once the run has overflowed, acc stays pinned at full scale.
    assign w_acc_next = (r_ovf || w_carry) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/status decode.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_acc_valid  = 1'b0;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid && (r_cnt == c_last_cnt)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_acc_valid  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Accumulator, term counter and sticky overflow; all hold unless cleared or a term lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= 4'd0;
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_cnt <= 4'd0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 4'd1;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.acc_valid = w_acc_valid;
    assign bus.acc       = r_acc;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Bench for sum_accumulator. Three instances (8-bit/4 terms,
//               6-bit/4 terms, 8-bit/1 term) share one stimulus stream and
//               are compared every cycle against a run-level integer model,
//               with directed literal expectations pinning key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] s;
    logic       co;

    int total = 0;
    int bad   = 0;

    sum_accumulator_if #(.ACC_W(8)) if8 ();
    sum_accumulator_if #(.ACC_W(6)) if6 ();
    sum_accumulator_if #(.ACC_W(8)) if1 ();

    assign if8.start = start;  assign if8.in_valid = in_valid;
    assign if8.s     = s;      assign if8.co       = co;
    assign if6.start = start;  assign if6.in_valid = in_valid;
    assign if6.s     = s;      assign if6.co       = co;
    assign if1.start = start;  assign if1.in_valid = in_valid;
    assign if1.s     = s;      assign if1.co       = co;

    sum_accumulator #(.ACC_W(8), .NUM_TERMS(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    sum_accumulator #(.ACC_W(6), .NUM_TERMS(4)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
    sum_accumulator #(.ACC_W(8), .NUM_TERMS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Uniform views of the three instances' outputs.
    logic [15:0] acc_o   [3];
    logic        rdy_o   [3];
    logic        vld_o   [3];
    logic        busy_o  [3];
    logic        ovf_o   [3];
    assign acc_o[0] = 16'(if8.acc); assign acc_o[1] = 16'(if6.acc); assign acc_o[2] = 16'(if1.acc);
    assign rdy_o[0] = if8.in_ready; assign rdy_o[1] = if6.in_ready; assign rdy_o[2] = if1.in_ready;
    assign vld_o[0] = if8.acc_valid; assign vld_o[1] = if6.acc_valid; assign vld_o[2] = if1.acc_valid;
    assign busy_o[0] = if8.busy;    assign busy_o[1] = if6.busy;    assign busy_o[2] = if1.busy;
    assign ovf_o[0] = if8.ovf;      assign ovf_o[1] = if6.ovf;      assign ovf_o[2] = if1.ovf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting terms, 2 result cycle. tot is the exact integer sum.
    int     phase [3];
    int     taken [3];
    longint tot   [3];

    function automatic int wid(input int i);
        return (i == 1) ? 6 : 8;
    endfunction

    function automatic int nterms(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] exp_acc(input int i);
        longint full;
        full = longint'(1) << wid(i);
`ifdef SUM_ACC_SATURATE_EN
        return (tot[i] >= full) ? 32'(full - 1) : 32'(tot[i]);
`else
        return 32'(tot[i] % full);
`endif
    endfunction

    function automatic logic [31:0] exp_ovf(input int i);
        return (tot[i] >= (longint'(1) << wid(i))) ? 32'd1 : 32'd0;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            phase[i] = 0; taken[i] = 0; tot[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    phase[i] = 0; taken[i] = 0; tot[i] = 0;
                end else if (phase[i] == 0) begin
                    if (start) begin
                        phase[i] = 1; taken[i] = 0; tot[i] = 0;
                    end
                end else if (phase[i] == 1) begin
                    if (in_valid) begin
                        tot[i]   = tot[i] + longint'({co, s});
                        taken[i] = taken[i] + 1;
                        if (taken[i] == nterms(i)) phase[i] = 2;
                    end
                end else begin
                    phase[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    chk("acc",       i, 32'(acc_o[i]),  exp_acc(i));
                    chk("ovf",       i, 32'(ovf_o[i]),  exp_ovf(i));
                    chk("in_ready",  i, 32'(rdy_o[i]),  (phase[i] == 1) ? 32'd1 : 32'd0);
                    chk("busy",      i, 32'(busy_o[i]), (phase[i] != 0) ? 32'd1 : 32'd0);
                    chk("acc_valid", i, 32'(vld_o[i]),  (phase[i] == 2) ? 32'd1 : 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] term);
        in_valid  = 1'b1;
        {co, s}   = term;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        start = 1'b0; in_valid = 1'b0; s = 4'd0; co = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc",       0, 32'(if8.acc),       32'd0);
        chk("rst_busy",      0, 32'(if8.busy),      32'd0);
        chk("rst_in_ready",  0, 32'(if8.in_ready),  32'd0);
        chk("rst_acc_valid", 0, 32'(if8.acc_valid), 32'd0);
        chk("rst_ovf",       0, 32'(if8.ovf),       32'd0);
        rst_n = 1'b1;
        tick();

        // T1: 3,5,7,9 back-to-back.
        do_start();
        send(5'd3); send(5'd5); send(5'd7);
        chk("t1_no_early_valid", 0, 32'(if8.acc_valid), 32'd0);
        send(5'd9);
        chk("t1_acc",   0, 32'(if8.acc),       32'h18);
        chk("t1_valid", 0, 32'(if8.acc_valid), 32'd1);
        chk("t1_ovf",   0, 32'(if8.ovf),       32'd0);
        chk("t1_acc6",  1, 32'(if6.acc),       32'd24);
        tick();
        chk("t1_strobe_end", 0, 32'(if8.acc_valid), 32'd0);
        chk("t1_hold",       0, 32'(if8.acc),       32'h18);

        // T2: four times 31 overflows the 6-bit instance.
        do_start();
        repeat (4) send(5'd31);
`ifdef SUM_ACC_SATURATE_EN
        chk("t2_acc6", 1, 32'(if6.acc), 32'd63);
`else
        chk("t2_acc6", 1, 32'(if6.acc), 32'd60);
`endif
        chk("t2_ovf6", 1, 32'(if6.ovf), 32'd1);
        chk("t2_acc8", 0, 32'(if8.acc), 32'd124);
        chk("t2_ovf8", 0, 32'(if8.ovf), 32'd0);
        tick();

        // T3: gaps of three idle cycles between terms.
        do_start();
        for (int t = 1; t <= 4; t++) begin
            send(5'(t));
            if (t < 4) begin
                repeat (3) begin
                    s = 4'($urandom);
                    tick();
                    chk("t3_gap_hold", 0, 32'(if8.acc), 32'((t * (t + 1)) / 2));
                end
            end
        end
        chk("t3_acc",   0, 32'(if8.acc),       32'd10);
        chk("t3_valid", 0, 32'(if8.acc_valid), 32'd1);
        tick();

        // T4: asynchronous reset mid-run, between edges.
        do_start();
        send(5'd4); send(5'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_acc",      0, 32'(if8.acc),      32'd0);
        chk("t4_busy",     0, 32'(if8.busy),     32'd0);
        chk("t4_in_ready", 0, 32'(if8.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        do_start();
        repeat (4) send(5'd2);
        chk("t4_clean_acc", 0, 32'(if8.acc), 32'd8);
        chk("t4_clean_ovf", 0, 32'(if8.ovf), 32'd0);
        tick();

        // T5: start in ACCUM and DONE, in_valid in IDLE.
        do_start();
        send(5'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_accum_start_busy", 0, 32'(if8.busy), 32'd1);
        chk("t5_accum_start_acc",  0, 32'(if8.acc),  32'd5);
        send(5'd1); send(5'd1); send(5'd1);
        chk("t5_done_acc", 0, 32'(if8.acc), 32'd8);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_done_start_busy", 0, 32'(if8.busy), 32'd0);
        in_valid = 1'b1; {co, s} = 5'h1F;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t5_idle_valid_acc",  0, 32'(if8.acc),      32'd8);
        chk("t5_idle_valid_rdy",  0, 32'(if8.in_ready), 32'd0);

        // T6: single-term instance.
        do_start();
        send(5'h1F);
        chk("t6_acc",   2, 32'(if1.acc),       32'd31);
        chk("t6_valid", 2, 32'(if1.acc_valid), 32'd1);
        tick();
        chk("t6_valid_end", 2, 32'(if1.acc_valid), 32'd0);
        repeat (3) tick();
        chk("t6_hold", 2, 32'(if1.acc), 32'd31);
        do_start();
        chk("t6_cleared", 2, 32'(if1.acc), 32'd0);

        // Randomized traffic, checked by the model every cycle.
        repeat (500) begin
            start    = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            {co, s}  = 5'($urandom);
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
